tmds_channel_decoder: RTL and testbench

Receive-side counterpart of the DVI TMDS transmit path for one TMDS channel. Takes 10-bit parallel words from an external deserializer running in the pixel-clock domain, achieves word alignment by searching for control tokens and requesting bitslips, then decodes each 10-bit symbol back to 8-bit video data or 2-bit control data with a video-enable flag. Three instances (B/G/R) sit between the deserializer and the capture/timing-recovery logic; the blue instance's `oCD` carries {VSYNC, HSYNC}.

---
 rtl/tmds_channel_decoder.sv | 181 ++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment via control-token search/bitslip, then 10b->8b decode.
// Define TMDS_DEC_ERRCNT_EN to enable the saturating lock-loss counter on oErrCnt.
module tmds_channel_decoder #(
  parameter int unsigned LOCK_CNT  = 8,
  parameter int unsigned TIMEOUT   = 4095,
  parameter int unsigned SLIP_WAIT = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [9:0] iTmdsPara,
  output logic [7:0] oVD,
  output logic [1:0] oCD,
  output logic       oVDE,
  output logic       oBitslip,
  output logic       oLocked,
  output logic [7:0] oErrCnt
);

  typedef enum logic [1:0] {StSearch, StWait, StLocked} state_e;

  localparam logic [11:0] TimeoutLast = 12'(TIMEOUT - 1);
  localparam logic [11:0] SlipLast    = 12'(SLIP_WAIT - 1);
  localparam logic [3:0]  LockRun     = 4'(LOCK_CNT);

  state_e      state_q, state_d;
  logic [9:0]  tmds_q, tmds_d;
  logic [11:0] timer_q, timer_d;
  logic [3:0]  run_q, run_d;
  logic        locked_q, locked_d;
  logic        bitslip_q, bitslip_d;
  logic [7:0]  vd_q, vd_d;
  logic [1:0]  cd_q, cd_d;
  logic        vde_q, vde_d;
`ifdef TMDS_DEC_ERRCNT_EN
  logic [7:0]  errcnt_q, errcnt_d;
`endif

  logic       is_tok;
  logic [1:0] tok_cd;
  logic [7:0] dat;
  logic [7:0] dec;
  logic [3:0] run_inc;

  assign tmds_d = iTmdsPara;

  always_comb begin
    is_tok = 1'b1;
    tok_cd = 2'b00;
    case (tmds_q)
      10'h354: tok_cd = 2'b00;
      10'h0AB: tok_cd = 2'b01;
      10'h154: tok_cd = 2'b10;
      10'h2AB: tok_cd = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the transmitter's optional inversion, then its XOR/XNOR chain.
  always_comb begin
    dat    = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
    dec    = '0;
    dec[0] = dat[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = tmds_q[8] ? (dat[i] ^ dat[i-1]) : ~(dat[i] ^ dat[i-1]);
    end
  end

  // Masking uses the registered lock flag, so outputs follow oLocked by one edge.
  always_comb begin
    vd_d  = 8'h00;
    cd_d  = 2'b00;
    vde_d = 1'b0;
    if (locked_q) begin
      if (is_tok) begin
        cd_d = tok_cd;
      end else begin
        vd_d  = dec;
        cd_d  = cd_q;
        vde_d = 1'b1;
      end
    end
  end

  assign run_inc = is_tok ? run_q + 4'd1 : 4'd0;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    run_d     = run_q;
    locked_d  = locked_q;
    bitslip_d = 1'b0;
`ifdef TMDS_DEC_ERRCNT_EN
    errcnt_d  = errcnt_q;
`endif
    case (state_q)
      StSearch: begin
        if (run_inc == LockRun) begin
          state_d  = StLocked;
          locked_d = 1'b1;
          timer_d  = 12'd0;
          run_d    = 4'd0;
        end else if (timer_q == TimeoutLast) begin
          state_d   = StWait;
          bitslip_d = 1'b1;
          timer_d   = 12'd0;
          run_d     = 4'd0;
        end else begin
          timer_d = timer_q + 12'd1;
          run_d   = run_inc;
        end
      end
      StWait: begin
        if (timer_q == SlipLast) begin
          state_d = StSearch;
          timer_d = 12'd0;
          run_d   = 4'd0;
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      StLocked: begin
        if (is_tok) begin
          timer_d = 12'd0;
        end else if (timer_q == TimeoutLast) begin
          state_d  = StSearch;
          locked_d = 1'b0;
          timer_d  = 12'd0;
          run_d    = 4'd0;
`ifdef TMDS_DEC_ERRCNT_EN
          if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
`endif
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= StSearch;
      tmds_q    <= 10'h000;
      timer_q   <= 12'd0;
      run_q     <= 4'd0;
      locked_q  <= 1'b0;
      bitslip_q <= 1'b0;
      vd_q      <= 8'h00;
      cd_q      <= 2'b00;
      vde_q     <= 1'b0;
`ifdef TMDS_DEC_ERRCNT_EN
      errcnt_q  <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      tmds_q    <= tmds_d;
      timer_q   <= timer_d;
      run_q     <= run_d;
      locked_q  <= locked_d;
      bitslip_q <= bitslip_d;
      vd_q      <= vd_d;
      cd_q      <= cd_d;
      vde_q     <= vde_d;
`ifdef TMDS_DEC_ERRCNT_EN
      errcnt_q  <= errcnt_d;
`endif
    end
  end

  assign oVD      = vd_q;
  assign oCD      = cd_q;
  assign oVDE     = vde_q;
  assign oBitslip = bitslip_q;
  assign oLocked  = locked_q;
`ifdef TMDS_DEC_ERRCNT_EN
  assign oErrCnt  = errcnt_q;
`else
  assign oErrCnt  = 8'h00;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: one word driven per cycle, output compared two
// cycles later; alignment, lock-loss and reset behaviour checked directly.
module tb_tmds_channel_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] tmds;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde;
  logic       bitslip;
  logic       locked;
  logic [7:0] errcnt;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .LOCK_CNT (8),
    .TIMEOUT  (64),
    .SLIP_WAIT(16)
  ) dut (
    .iClk     (clk),
    .iRst     (rst),
    .iTmdsPara(tmds),
    .oVD      (vd),
    .oCD      (cd),
    .oVDE     (vde),
    .oBitslip (bitslip),
    .oLocked  (locked),
    .oErrCnt  (errcnt)
  );

`ifdef TMDS_DEC_ERRCNT_EN
  localparam int unsigned ErrExp = 1;
`else
  localparam int unsigned ErrExp = 0;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [10:0] exp_q[$];   // {vde, cd, vd}
  logic [1:0]  last_cd = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] classify(input logic [9:0] w);
    case (w)
      10'h354: return 3'b100;
      10'h0AB: return 3'b101;
      10'h154: return 3'b110;
      10'h2AB: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] o;
    d    = w[9] ? ~w[7:0] : w[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~w[8];
    return o;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    logic [2:0] c;
    w = 10'(($urandom_range(0, 1023)));
    c = classify(w);
    while (c[2]) begin
      w = 10'(($urandom_range(0, 1023)));
      c = classify(w);
    end
    return w;
  endfunction

  // Compare the word driven two cycles ago, then drive w and queue its expected output.
  task automatic drive(input logic [9:0] w, input logic on);
    logic [10:0] e;
    logic [2:0]  c;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("vde", 32'(vde), 32'(e[10]));
      check("cd",  32'(cd),  32'(e[9:8]));
      check("vd",  32'(vd),  32'(e[7:0]));
    end
    tmds = w;
    c    = classify(w);
    if (!on) begin
      e       = '0;
      last_cd = 2'b00;
    end else if (c[2]) begin
      e       = {1'b0, c[1:0], 8'h00};
      last_cd = c[1:0];
    end else begin
      e = {1'b1, last_cd, ref_decode(w)};
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first, second, pulses;
    logic        lock_seen;
    logic [9:0]  data_tbl[6];
    data_tbl = '{10'h000, 10'h1F0, 10'h3C3, 10'h0A5, 10'h255, 10'h3FF};
    rst  = 1'b1;
    tmds = 10'h354;
    @(negedge clk);

    // Reset with a token on the input
    for (int i = 0; i < 3; i++) drive(10'h354, 1'b0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_bitslip", 32'(bitslip), 32'd0);
    check("rst_vde", 32'(vde), 32'd0);
    check("rst_vd", 32'(vd), 32'd0);
    check("rst_cd", 32'(cd), 32'd0);
    check("rst_errcnt", 32'(errcnt), 32'd0);
    rst = 1'b0;

    // Misaligned stream: rotated token never matches
    first = -1; second = -1; pulses = 0; lock_seen = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      drive(10'h1A9, 1'b0);
      if (bitslip) begin
        pulses++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (locked) lock_seen = 1'b1;
    end
    check("slip_first", 32'(first), 32'd64);
    check("slip_second", 32'(second), 32'd144);
    check("slip_count", 32'(pulses), 32'd2);
    check("slip_nolock", 32'(lock_seen), 32'd0);

    // Lock and decode
    rst = 1'b1;
    drive(10'h354, 1'b0);
    drive(10'h354, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) drive(10'h354, 1'b0);
    check("lock_early", 32'(locked), 32'd0);
    drive(10'h101, 1'b1);
    check("lock_rise", 32'(locked), 32'd1);
    drive(10'h2FF, 1'b1);
    check("vd_101", 32'(vd), 32'h03);
    check("vde_101", 32'(vde), 32'd1);
    drive(10'h354, 1'b1);
    check("vd_2ff", 32'(vd), 32'hFE);
    check("vde_2ff", 32'(vde), 32'd1);

    // Control tokens and data patterns while locked
    drive(10'h0AB, 1'b1);
    drive(10'h154, 1'b1);
    drive(10'h2AB, 1'b1);
    foreach (data_tbl[i]) drive(data_tbl[i], 1'b1);

    // Timeout boundary: 63 data words then a token keeps lock
    drive(10'h354, 1'b1);
    for (int i = 0; i < 63; i++) drive(rand_data(), 1'b1);
    drive(10'h0AB, 1'b1);
    check("hold_lock", 32'(locked), 32'd1);
    for (int i = 0; i < 64; i++) drive(rand_data(), 1'b1);
    check("unlock_early", 32'(locked), 32'd1);
    drive(rand_data(), 1'b0);
    check("unlock", 32'(locked), 32'd0);
    check("errcnt", 32'(errcnt), 32'(ErrExp));
    for (int i = 0; i < 3; i++) drive(rand_data(), 1'b0);
    check("masked_vde", 32'(vde), 32'd0);

    // Reset in the middle of a locked data stream
    for (int i = 0; i < 8; i++) drive(10'h354, 1'b0);
    for (int i = 0; i < 3; i++) drive(rand_data(), 1'b1);
    check("relock", 32'(locked), 32'd1);
    drive(rand_data(), 1'b0);
    rst = 1'b1;
    drive(rand_data(), 1'b0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_vde", 32'(vde), 32'd0);
    check("mid_rst_errcnt", 32'(errcnt), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) drive(10'h354, 1'b0);
    drive(rand_data(), 1'b0);
    drive(rand_data(), 1'b0);
    check("short_run_nolock", 32'(locked), 32'd0);
    for (int i = 0; i < 8; i++) drive(10'h354, 1'b0);
    drive(rand_data(), 1'b1);
    check("fresh_lock", 32'(locked), 32'd1);
    drive(rand_data(), 1'b1);
    drive(10'h154, 1'b1);
    drive(rand_data(), 1'b1);
    drive(rand_data(), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
